imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction RAM. Accepts a byte stream over a valid/ready handshake (fed from a UART receiver or testbench), assembles little-endian 32-bit words, and issues one write per word into instruction memory starting at address 0. It holds the CPU core in reset while loading and releases it once the image is complete.

## Interface
- `MAX_WORDS`, 1024: largest accepted image, in words. Must be at most 65535.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a load.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader can accept a byte. A byte transfers on a cycle where `rx_valid` and `rx_ready` are both high.
- `mem_we` out 1: instruction RAM write strobe, high for one cycle per word.
- `mem_addr` out 32: byte address, word-aligned (4·index).
- `mem_wdata` out 32: assembled word.
- `core_rst` out 1: reset to the core; high except in DONE.
- `busy` out 1: a load is in progress.
- `done` out 1: image loaded; the core is running.
- `error` out 1: load aborted.
- `word_cnt` out 16: words written so far in the current load.

## Operation
- States:
  - IDLE: waits for `start`.
  - LEN_LO, LEN_HI: receive the 16-bit word count N, low byte first.
  - DATA: receives 4·N bytes.
  - FLUSH: present only without the checksum feature.
  - CSUM: present only with the checksum feature.
  - DONE, ERR.
- `rx_ready` is 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in every other state.
- Transitions:
  - IDLE + `start` → LEN_LO.
  - LEN_LO + byte → LEN_HI.
  - LEN_HI + byte:
    - N > MAX_WORDS → ERR.
    - N = 0 → DONE, or CSUM when the checksum feature is compiled in.
    - Otherwise → DATA.
- DATA, byte lane order: byte k of a word lands in `mem_wdata[8k+7:8k]`, so the first byte received is bits 7:0.
- DATA, write generation: accepting byte 3 of word i registers `mem_we`=1, `mem_addr`=4i and `mem_wdata`=word for the next cycle. `word_cnt` increments with the strobe.
- The next byte may be accepted during that write cycle; assembly uses a separate buffer.
- Last byte of word N−1 → FLUSH (one cycle, carries the final `mem_we`) → DONE.
- DONE and ERR are held until `start` or `rst`.
- `start` in DONE or ERR → LEN_LO. This clears `done`, `error` and `word_cnt` and reasserts `core_rst`.
- `start` in any other state is ignored.
- `busy` = 1 in LEN_LO, LEN_HI, DATA, FLUSH and CSUM.
- `error` = 1 only in ERR. `done` = 1 only in DONE.
- No `mem_we` occurs outside DATA, FLUSH and CSUM. There are never more than N writes.

## Timing
- Reset values:
  - State IDLE.
  - `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `core_rst`=1, `busy`=0, `done`=0, `error`=0, `word_cnt`=0.
- `rst` mid-load: every reset value applies on the next edge. Any pending write is dropped.
- `start` in IDLE at edge t: `rx_ready`=1 from cycle t+1.
- Write latency: byte 3 accepted at edge t → `mem_we` high in cycle t+1 only.
- Release: `core_rst` falls at the edge after the final `mem_we` cycle. The last write therefore lands before the core fetches from address 0.
- With continuous `rx_valid`: one byte per cycle, so 4N+2 transfer cycles plus one flush/checksum cycle.
- Gaps in `rx_valid` stall the FSM without side effects. `mem_*` outputs other than `mem_we` hold their values.

## Configuration
- Macro: `IMEM_LOADER_CSUM_EN`.
- Defined:
  - After the last data byte (or after the header when N=0), the FSM enters CSUM. The final `mem_we` occurs in CSUM's first cycle.
  - CSUM accepts one byte and compares it with the 8-bit wrap-around sum of all data bytes (the length bytes are not included).
  - Match → DONE. Mismatch → ERR, and `core_rst` stays 1. Words already written are not rolled back.
- Undefined: no CSUM state and no checksum byte; FLUSH is used instead.

## Test plan
- N=2, stream `02 00 13 05 00 00 93 01 10 00` with `rx_valid` held high:
  - Writes 0x00000513 at address 0, then 0x00100193 at address 4.
  - `word_cnt`=2, `done`=1, `core_rst`=0 the cycle after the second write.
- Same stream with `rx_valid` deasserted for 3 cycles between every byte → identical writes and final state; the FSM does not advance during the gaps.
- N=0 (`00 00`) → no `mem_we`, `done`=1 (with `IMEM_LOADER_CSUM_EN`, the byte `00` is required before `done`).
- N=MAX_WORDS+1 → `error`=1 and `rx_ready`=0 after the header. No `mem_we`; `core_rst` stays 1. A subsequent `start` returns to LEN_LO with `error`=0.
- `rst` asserted after 5 data bytes of an N=2 load → all reset values on the next cycle. Exactly one write (address 0), and no further writes.
- With `IMEM_LOADER_CSUM_EN`, N=1, data `13 05 00 00`:
  - Checksum byte `18` → `done`=1.
  - Checksum byte `19` → `error`=1 and `core_rst`=1, with the word still written at address 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// master = loader side, slave = byte source / RAM side.
interface imem_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: 16-bit word count then little-endian words written to IMEM from address 0; core held in reset until done.
// Define IMEM_LOADER_CSUM_EN to require a trailing 8-bit sum-of-data-bytes checksum.
module imem_loader #(
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          core_rst,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [15:0]   word_cnt
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM,
`else
      ST_FLUSH,
`endif
      ST_DONE,
      ST_ERR
   } state_t;

`ifdef IMEM_LOADER_CSUM_EN
   localparam state_t ST_TAIL  = ST_CSUM;
   localparam state_t ST_EMPTY = ST_CSUM;
`else
   localparam state_t ST_TAIL  = ST_FLUSH;
   localparam state_t ST_EMPTY = ST_DONE;
`endif

   state_t        state_q, state_d;
   logic          rx_ready_q, rdy_d;
   logic          busy_q, busy_d;
   logic          mem_we_q;
   logic [31:0]   mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic          core_rst_q;
   logic          done_q;
   logic          error_q;
   logic [15:0]   word_cnt_q;
   logic [7:0]    len_lo_q;
   logic [15:0]   len_q;
   logic [1:0]    byte_idx_q;
   logic [23:0]   asm_q;
`ifdef IMEM_LOADER_CSUM_EN
   logic [7:0]    sum_q;
`endif

   logic          xfer;
   logic          restart;
   logic [15:0]   len_in;
   logic          last_byte;
   logic          last_word;

   assign xfer      = bus.rx_valid & rx_ready_q;
   assign restart   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
   assign len_in    = {bus.rx_data, len_lo_q};
   assign last_byte = (byte_idx_q == 2'd3);
   // word_cnt_q still indexes the word being completed when its last byte arrives
   assign last_word = (word_cnt_q == (len_q - 16'd1));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) state_d = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (xfer) begin
               if (32'(len_in) > MAX_WORDS) state_d = ST_ERR;
               else if (len_in == 16'd0)    state_d = ST_EMPTY;
               else                         state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (xfer && last_byte && last_word) state_d = ST_TAIL;
         end
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: begin
            if (xfer) state_d = (bus.rx_data == sum_q) ? ST_DONE : ST_ERR;
         end
`else
         ST_FLUSH: begin
            state_d = ST_DONE;
         end
`endif
         ST_DONE, ST_ERR: begin
            if (start) state_d = ST_LEN_LO;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rdy_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA);
      busy_d = rdy_d;
`ifdef IMEM_LOADER_CSUM_EN
      rdy_d  = rdy_d  || (state_d == ST_CSUM);
      busy_d = busy_d || (state_d == ST_CSUM);
`else
      busy_d = busy_d || (state_d == ST_FLUSH);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rx_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         core_rst_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         word_cnt_q  <= 16'd0;
         len_lo_q    <= 8'd0;
         len_q       <= 16'd0;
         byte_idx_q  <= 2'd0;
         asm_q       <= 24'd0;
`ifdef IMEM_LOADER_CSUM_EN
         sum_q       <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         rx_ready_q <= rdy_d;
         busy_q     <= busy_d;
         done_q     <= (state_d == ST_DONE);
         error_q    <= (state_d == ST_ERR);
         core_rst_q <= (state_d != ST_DONE);
         mem_we_q   <= 1'b0;

         if (restart) begin
            word_cnt_q <= 16'd0;
            byte_idx_q <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q      <= 8'd0;
`endif
         end

         if (xfer) begin
            unique case (state_q)
               ST_LEN_LO: len_lo_q <= bus.rx_data;
               ST_LEN_HI: len_q    <= len_in;
               ST_DATA: begin
                  byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                  sum_q      <= sum_q + bus.rx_data;
`endif
                  unique case (byte_idx_q)
                     2'd0: asm_q[7:0]   <= bus.rx_data;
                     2'd1: asm_q[15:8]  <= bus.rx_data;
                     2'd2: asm_q[23:16] <= bus.rx_data;
                     default: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {14'd0, word_cnt_q, 2'b00};
                        mem_wdata_q <= {bus.rx_data, asm_q};
                        word_cnt_q  <= word_cnt_q + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign core_rst      = core_rst_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole-image loads plus reset, ignored-start and checksum sequences.
// Expected RAM writes go into a queue as bytes are driven and are popped by a write monitor.
module tb_imem_loader;
   localparam int MAXW = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        core_rst;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] word_cnt;

   imem_loader_if bus();

   imem_loader #(.MAX_WORDS(MAXW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .core_rst (core_rst),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  sum_acc;

   typedef struct {
      logic [15:0] n;
      int          nw;
      logic [31:0] w0;
      logic [31:0] w1;
      int          gap;
      logic        exp_done;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Every write strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_we: write addr 0x%0h data 0x%0h, none expected", bus.mem_addr, bus.mem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("we_addr", bus.mem_addr, e[63:32]);
            check("we_data", bus.mem_wdata, e[31:0]);
            check1("we_core_rst", core_rst, 1'b1);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      for (int i = 0; i < gap; i++) begin
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
         @(posedge clk); #1;
         check1("gap_rdy", bus.rx_ready, 1'b1);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      waited = 0;
      while (bus.rx_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 20) begin
         n_cmp++;
         n_fail++;
         $display("FAIL rdy_timeout: rx_ready=%b after 20 cycles, expected 1", bus.rx_ready);
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_header(input logic [15:0] n, input int gap);
      sum_acc = 8'd0;
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
   endtask

   task automatic send_word(input int idx, input logic [31:0] w, input int gap);
      logic [7:0] b;
      for (int k = 0; k < 4; k++) begin
         b = w[8*k +: 8];
         if (k == 3) exp_q.push_back({32'(idx * 4), w});
         sum_acc = sum_acc + b;
         send_byte(b, gap);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_reset();
      check1("rst_rx_ready", bus.rx_ready, 1'b0);
      check1("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check1("rst_core_rst", core_rst, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_error", error, 1'b0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
   endtask

   task automatic check_final(input logic d, input logic e, input logic [15:0] cnt);
      check1("fin_done", done, d);
      check1("fin_error", error, e);
      check1("fin_core_rst", core_rst, ~d);
      check1("fin_busy", busy, 1'b0);
      check1("fin_rx_ready", bus.rx_ready, 1'b0);
      check1("fin_mem_we", bus.mem_we, 1'b0);
      check("fin_word_cnt", 32'(word_cnt), 32'(cnt));
      check("fin_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // After the last data byte: either the flush cycle or the checksum byte.
   task automatic finish_image(input logic [7:0] csum, input int gap);
`ifdef IMEM_LOADER_CSUM_EN
      send_byte(csum, gap);
`else
      check1("we_latency", bus.mem_we, 1'b1);
      check1("flush_core_rst", core_rst, 1'b1);
      @(posedge clk); #1;
      if (csum !== 8'hxx) begin end
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{n: 16'd2, nw: 2, w0: 32'h0000_0513, w1: 32'h0010_0193, gap: 0,
                  exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 16'd2};
      vecs[1] = '{n: 16'd2, nw: 2, w0: 32'h0000_0513, w1: 32'h0010_0193, gap: 3,
                  exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 16'd2};
      vecs[2] = '{n: 16'd0, nw: 0, w0: 32'd0, w1: 32'd0, gap: 0,
                  exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 16'd0};
      vecs[3] = '{n: 16'(MAXW + 1), nw: 0, w0: 32'd0, w1: 32'd0, gap: 0,
                  exp_done: 1'b0, exp_err: 1'b1, exp_cnt: 16'd0};
      vecs[4] = '{n: 16'd1, nw: 1, w0: 32'hDEAD_BEEF, w1: 32'd0, gap: 1,
                  exp_done: 1'b1, exp_err: 1'b0, exp_cnt: 16'd1};

      rst          = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'd0;
      sum_acc      = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         pulse_start();
         check1("start_rx_ready", bus.rx_ready, 1'b1);
         check1("start_busy", busy, 1'b1);
         check1("start_done", done, 1'b0);
         check1("start_error", error, 1'b0);
         check1("start_core_rst", core_rst, 1'b1);
         check("start_word_cnt", 32'(word_cnt), 32'd0);
         send_header(vecs[i].n, vecs[i].gap);
         for (int w = 0; w < vecs[i].nw; w++)
            send_word(w, (w == 0) ? vecs[i].w0 : vecs[i].w1, vecs[i].gap);
`ifdef IMEM_LOADER_CSUM_EN
         if (!vecs[i].exp_err) finish_image(sum_acc, vecs[i].gap);
`else
         if (!vecs[i].exp_err && vecs[i].n != 16'd0) finish_image(sum_acc, vecs[i].gap);
`endif
         check_final(vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_cnt);
      end

      // Reset after five data bytes: one write already issued, nothing after.
      pulse_start();
      send_header(16'd2, 0);
      send_word(0, 32'h0000_0513, 0);
      send_byte(8'h93, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset();
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("rst_pending", 32'(exp_q.size()), 32'd0);
      check1("rst_idle_core_rst", core_rst, 1'b1);

      // A start pulse in the middle of DATA must not disturb the load.
      pulse_start();
      send_header(16'd2, 0);
      send_word(0, 32'h1122_3344, 0);
      pulse_start();
      check("ign_word_cnt", 32'(word_cnt), 32'd1);
      check1("ign_busy", busy, 1'b1);
      check1("ign_rx_ready", bus.rx_ready, 1'b1);
      send_word(1, 32'h5566_7788, 0);
      finish_image(sum_acc, 0);
      check_final(1'b1, 1'b0, 16'd2);

`ifdef IMEM_LOADER_CSUM_EN
      pulse_start();
      send_header(16'd1, 0);
      send_word(0, 32'h0000_0513, 0);
      send_byte(8'h18, 0);
      check_final(1'b1, 1'b0, 16'd1);

      pulse_start();
      send_header(16'd1, 0);
      send_word(0, 32'h0000_0513, 0);
      send_byte(8'h19, 0);
      check_final(1'b0, 1'b1, 16'd1);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("end_pending", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
